// File: rtl/logic_unit_scheduler_if.sv
// Request/response bundle for the shared logic-unit scheduler.
// master = client side, slave = scheduler side.
interface logic_unit_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*3-1:0]      req_op;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/logic_unit_scheduler.sv
// Round-robin shared bitwise logic unit with one registered response slot.
// Define LU_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module logic_unit_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  logic_unit_scheduler_if.slave bus
`ifdef LU_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt
`endif
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              found;
  logic [ID_W-1:0]   grant;
  logic              accept_ok;
  logic              accept;
  logic [DATA_W-1:0] op_a, op_b, res;
  logic [2:0]        op;

  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        grant = ID_W'(j);
      end
    end
  end

  // Gated by rst_n so no request is acknowledged while reset is held.
  assign accept_ok = (state_q == EMPTY) || bus.rsp_ready;
  assign accept    = found && accept_ok && rst_n;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant] = 1'b1;
  end

  assign op_a = bus.req_a[int'(grant)*DATA_W +: DATA_W];
  assign op_b = bus.req_b[int'(grant)*DATA_W +: DATA_W];
  assign op   = bus.req_op[int'(grant)*3 +: 3];

  always_comb begin
    res = '0;
    unique case (op)
      3'd0: res = op_a & op_b;
      3'd1: res = op_a | op_b;
      3'd2: res = ~op_a;
      3'd3: res = ~op_b;
      3'd4: res = ~(op_a & op_b);
      3'd5: res = ~(op_a | op_b);
      3'd6: res = op_a ^ op_b;
      3'd7: res = ~(op_a ^ op_b);
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    id_d    = id_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (bus.rsp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      data_d = res;
      id_d   = grant;
      ptr_d  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_id    = id_q;

`ifdef LU_STATS_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept && (grant == ID_W'(i)) && (cnt_q[i] != {CNT_W{1'b1}}))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif
endmodule

// File: tb/tb_logic_unit_scheduler.sv
// Directed bench for logic_unit_scheduler.
// Covers reset, single request, all ops, backpressure, fairness, stats.
module tb_logic_unit_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
`ifdef LU_STATS_EN
  localparam int CNT_W   = 2;
`else
  localparam int CNT_W   = 16;
`endif

  logic clk;
  logic rst_n;
  int   vecs;
  int   miss;

  logic_unit_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

`ifdef LU_STATS_EN
  logic [NUM_REQ*CNT_W-1:0] grant_cnt;
`endif

  logic_unit_scheduler #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
`ifdef LU_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] op);
    bus.req_a[i*DATA_W +: DATA_W] = a;
    bus.req_b[i*DATA_W +: DATA_W] = b;
    bus.req_op[i*3 +: 3]          = op;
  endtask

  logic [7:0] op_exp [8];

  initial begin
    vecs = 0;
    miss = 0;
    op_exp[0] = 8'h88; op_exp[1] = 8'hEE;
    op_exp[2] = 8'h55; op_exp[3] = 8'h33;
    op_exp[4] = 8'h77; op_exp[5] = 8'h11;
    op_exp[6] = 8'h66; op_exp[7] = 8'h99;

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_data",  32'(bus.rsp_data),  32'h00);
    chk("rst_id",    32'(bus.rsp_id),    32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);

    // single request on requester 2, XOR
    set_req(2, 8'hF0, 8'h3C, 3'd6);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = '0;
    chk("single_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_data",  32'(bus.rsp_data),  32'hCC);
    chk("single_id",    32'(bus.rsp_id),    32'd2);
    step();
    chk("single_drain", 32'(bus.rsp_valid), 32'd0);

    // every op back-to-back on requester 1
    for (int op = 0; op < 8; op++) begin
      set_req(1, 8'hAA, 8'hCC, 3'(op));
      bus.req_valid = 4'b0010;
      step();
      chk($sformatf("op%0d_data", op), 32'(bus.rsp_data), 32'(op_exp[op]));
      chk($sformatf("op%0d_id", op),   32'(bus.rsp_id),   32'd1);
    end
    bus.req_valid = '0;
    step();
    chk("ops_drain", 32'(bus.rsp_valid), 32'd0);

    // backpressure; ptr is 2 here so req0 wins after wraparound
    bus.rsp_ready = 1'b0;
    set_req(0, 8'h0F, 8'hF0, 3'd1);
    bus.req_valid = 4'b0001;
    #1;
    chk("bp_ready0", 32'(bus.req_ready), 32'h1);
    step();
    set_req(2, 8'hFF, 8'h0F, 3'd0);
    bus.req_valid = 4'b0100;
    #1;
    chk("bp_stall_ready", 32'(bus.req_ready), 32'h0);
    chk("bp_valid",       32'(bus.rsp_valid), 32'd1);
    chk("bp_data",        32'(bus.rsp_data),  32'hFF);
    chk("bp_id",          32'(bus.rsp_id),    32'd0);
    step();
    chk("bp_hold_data",  32'(bus.rsp_data),  32'hFF);
    chk("bp_hold_id",    32'(bus.rsp_id),    32'd0);
    chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_hold_ready", 32'(bus.req_ready), 32'h0);
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'h4);
    step();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    chk("bp2_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp2_data",  32'(bus.rsp_data),  32'h0F);
    chk("bp2_id",    32'(bus.rsp_id),    32'd2);

    // async reset mid-response, ptr is 3 beforehand
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(8'h11 * i), 8'h00, 3'd1);
    bus.req_valid = 4'b1111;
    #1;
    chk("full_ready", 32'(bus.req_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("arst_data",  32'(bus.rsp_data),  32'h00);
    chk("arst_id",    32'(bus.rsp_id),    32'd0);
    chk("arst_ready", 32'(bus.req_ready), 32'h0);
    step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    chk("arst_ptr0", 32'(bus.req_ready), 32'h1);

    // fairness: all valid, one grant per cycle in order
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("rr%0d_id", k),    32'(bus.rsp_id),    32'(k % 4));
      chk($sformatf("rr%0d_data", k),  32'(bus.rsp_data),  32'(8'h11 * (k % 4)));
      chk($sformatf("rr%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
    end
    bus.req_valid = '0;
    step();
    chk("rr_drain", 32'(bus.rsp_valid), 32'd0);

    // five grants to requester 0 after a fresh reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_req(0, 8'h5A, 8'h00, 3'd1);
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("r0_%0d_id", k),   32'(bus.rsp_id),   32'd0);
      chk($sformatf("r0_%0d_data", k), 32'(bus.rsp_data), 32'h5A);
    end
    bus.req_valid = '0;
    step();
    chk("r0_drain", 32'(bus.rsp_valid), 32'd0);
`ifdef LU_STATS_EN
    chk("cnt0_sat", 32'(grant_cnt[0*CNT_W +: CNT_W]), 32'd3);
    chk("cnt1",     32'(grant_cnt[1*CNT_W +: CNT_W]), 32'd0);
    chk("cnt2",     32'(grant_cnt[2*CNT_W +: CNT_W]), 32'd0);
    chk("cnt3",     32'(grant_cnt[3*CNT_W +: CNT_W]), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
